// File: rtl/moving_average_seq.sv
// -----------------------------------------------------------------------------
// moving_average_seq
//   Sequencer in front of the tt_um_moving_average filter datapath. Takes one
//   sample at a time from a valid/ready input stream and issues one filter
//   strobe per sample. It holds the filter's data_in stable until the filter
//   answers, then captures the average and offers it on a valid/ready output
//   stream. It also provides:
//     - a programmable idle gap after each sample,
//     - optional suppression of the first 2^FILTER_POWER averages (warm-up),
//     - a watchdog on the filter's completion strobe,
//     - a soft clear.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   clear               synchronous soft clear pulse
//   s_data/s_valid/s_ready    input sample stream
//   m_data/m_valid/m_ready    output average stream
//   f_data_in/f_strobe_in/f_reset   drive the filter
//   f_data_out/f_strobe_out         returned by the filter
//   cfg_gap             idle cycles enforced after each sample
//   cfg_skip_warm       discard the first 2^FILTER_POWER averages after reset/clear
//   err_timeout         sticky watchdog abort flag
//   busy                high in every state except IDLE
//   out_count           output handshake counter (wraps)
// -----------------------------------------------------------------------------
module moving_average_seq #(
  parameter int FILTER_POWER = 2,
  parameter int DATA_IN_LEN  = 10,
  parameter int GAP_W        = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [DATA_IN_LEN-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_IN_LEN-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_IN_LEN-1:0] f_data_in,
  output logic                   f_strobe_in,
  output logic                   f_reset,
  input  logic [DATA_IN_LEN-1:0] f_data_out,
  input  logic                   f_strobe_out,
  input  logic [GAP_W-1:0]       cfg_gap,
  input  logic                   cfg_skip_warm,
  output logic                   err_timeout,
  output logic                   busy,
  output logic [15:0]            out_count
);

  localparam int WIN    = 1 << FILTER_POWER;
  localparam int WARM_W = FILTER_POWER + 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_F  = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4,
    GAP     = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_IN_LEN-1:0] hold_q, hold_d;
  logic [DATA_IN_LEN-1:0] mdata_q, mdata_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   frst_q;
  logic                   rst_prev_q;
  logic                   leave;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mdata_d = mdata_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    warm_d  = warm_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    leave   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          hold_d  = s_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_F;
      end
      WAIT_F: begin
        // A completion strobe in the final watchdog cycle still wins.
        if (f_strobe_out) begin
          state_d = CAPTURE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          leave = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      CAPTURE: begin
        // The filter output register updates on the strobe_out edge, so the
        // fresh average is only visible here, one cycle later.
        mdata_d = f_data_out;
        if (cfg_skip_warm && (warm_q < WARM_W'(WIN))) begin
          warm_d = warm_q + WARM_W'(1);
          leave  = 1'b1;
        end else begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          cnt_d = cnt_q + 16'd1;
          leave = 1'b1;
        end
      end
      GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Gap length is sampled here, on entry; a zero gap returns straight to IDLE
    // so back-to-back samples run at full rate.
    if (leave) begin
      if (cfg_gap == '0) begin
        state_d = IDLE;
      end else begin
        state_d = GAP;
        gap_d   = cfg_gap;
      end
    end

    // Soft clear aborts whatever is in flight; counters and the error flag survive.
    if (clear) begin
      state_d = IDLE;
      hold_d  = hold_q;
      warm_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      mdata_q    <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      warm_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      frst_q     <= 1'b1;
      rst_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      mdata_q    <= mdata_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      warm_q     <= warm_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      // Stretch the filter reset one cycle past the release edge, or one
      // cycle after a clear is seen.
      frst_q     <= clear | rst_prev_q;
      rst_prev_q <= 1'b0;
    end
  end

  assign s_ready     = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign m_valid     = (state_q == OUTPUT);
  assign m_data      = mdata_q;
  assign f_strobe_in = (state_q == ISSUE);
  assign f_data_in   = hold_q;
  assign f_reset     = reset | frst_q;
  assign err_timeout = err_q;
  assign out_count   = cnt_q;

endmodule

// File: tb/tb_moving_average_seq.sv
// -----------------------------------------------------------------------------
// tb_moving_average_seq
//   Bench for moving_average_seq. A behavioural stand-in for the filter sits
//   on the f_* ports. It samples strobe_in, raises strobe_out in the 6th cycle
//   after that edge, and on the strobe_out edge folds data_in into a
//   4-deep window and registers the average.
//   Expected averages come from a queue-based window model kept in the bench.
// -----------------------------------------------------------------------------
module tb_moving_average_seq;

  localparam int P  = 2;
  localparam int W  = 10;
  localparam int GW = 8;
  localparam int TO = 64;
  localparam int WIN = 1 << P;

  logic          clk;
  logic          reset;
  logic          clear;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  f_data_in;
  logic          f_strobe_in;
  logic          f_reset;
  logic [W-1:0]  f_data_out;
  logic          f_strobe_out;
  logic [GW-1:0] cfg_gap;
  logic          cfg_skip_warm;
  logic          err_timeout;
  logic          busy;
  logic [15:0]   out_count;

  moving_average_seq #(
    .FILTER_POWER(P), .DATA_IN_LEN(W), .GAP_W(GW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .f_data_in(f_data_in), .f_strobe_in(f_strobe_in), .f_reset(f_reset),
    .f_data_out(f_data_out), .f_strobe_out(f_strobe_out),
    .cfg_gap(cfg_gap), .cfg_skip_warm(cfg_skip_warm),
    .err_timeout(err_timeout), .busy(busy), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter stand-in
  logic         filt_dead;
  logic [W-1:0] fw [3];
  logic         f_active;
  int           f_cd;

  always @(posedge clk) begin
    if (f_reset) begin
      fw[0] <= '0; fw[1] <= '0; fw[2] <= '0;
      f_active <= 1'b0;
      f_cd <= 0;
      f_strobe_out <= 1'b0;
      f_data_out <= '0;
    end else begin
      f_strobe_out <= 1'b0;
      if (f_strobe_out) begin
        fw[0] <= f_data_in;
        fw[1] <= fw[0];
        fw[2] <= fw[1];
        f_data_out <= W'((int'(f_data_in) + int'(fw[0]) + int'(fw[1]) + int'(fw[2])) >> P);
      end
      if (f_active) begin
        if (f_cd == 0) begin
          f_strobe_out <= 1'b1;
          f_active <= 1'b0;
        end else begin
          f_cd <= f_cd - 1;
        end
      end else if (f_strobe_in && !filt_dead) begin
        f_active <= 1'b1;
        f_cd <= 4;
      end
    end
  end

  // Reference model and bookkeeping
  int          n_run;
  int          n_fail;
  int          m_win[$];
  int          m_warm;
  int          exp_q[$];
  logic [15:0] out_exp;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_win.delete();
    m_warm = 0;
  endtask

  task automatic model_push(input int d);
    int s;
    m_win.push_back(d);
    if (m_win.size() > WIN) void'(m_win.pop_front());
    s = 0;
    foreach (m_win[i]) s += m_win[i];
    if (cfg_skip_warm && m_warm < WIN) m_warm++;
    else exp_q.push_back(s / WIN);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input int d, input bit track);
    int k;
    k = 0;
    @(negedge clk);
    s_data  = W'(d);
    s_valid = 1'b1;
    while (!s_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) chk_eq("s_ready_wait", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (track) model_push(d);
  endtask

  task automatic wait_out(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!m_valid && k < 200);
    if (!m_valid) chk_eq("m_valid_wait", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int k, n, v, g;
    int t2_in [5];
    int t2_exp[5];
    t2_in  = '{4, 8, 12, 16, 20};
    t2_exp = '{1, 3, 6, 10, 14};
    n_run = 0; n_fail = 0; out_exp = '0; m_warm = 0;
    reset = 1'b1; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_gap = '0; cfg_skip_warm = 1'b0; filt_dead = 1'b0;

    // Output monitor: every accepted average is checked against the model.
    fork
      forever begin
        @(negedge clk);
        if (!reset && m_valid && m_ready) begin
          if (exp_q.size() == 0) chk_eq("m_valid_unexpected", 1, 0);
          else chk_eq("m_data", int'(m_data), exp_q.pop_front());
          out_exp = out_exp + 16'd1;
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_f_reset_held", f_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_eq("rst_s_ready", s_ready, 1);
    chk_eq("rst_m_valid", m_valid, 0);
    chk_eq("rst_m_data", m_data, 0);
    chk_eq("rst_f_strobe_in", f_strobe_in, 0);
    chk_eq("rst_f_data_in", f_data_in, 0);
    chk_eq("rst_err", err_timeout, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_out_count", out_count, 0);
    chk_eq("rst_f_reset_after", f_reset, 1);
    step();
    chk_eq("rst_f_reset_drop", f_reset, 0);

    // Single sample: latency and average
    send(8, 1'b1);
    wait_out(k);
    chk_eq("t1_latency", k, 8);
    chk_eq("t1_m_data", m_data, 2);
    step();
    chk_eq("t1_out_count", out_count, 1);
    chk_eq("t1_idle", s_ready, 1);

    // clear and s_valid together in IDLE: clear wins
    @(negedge clk);
    s_data = 10'd7; s_valid = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; s_valid = 1'b0;
    chk_eq("clr_sv_not_taken", busy, 0);
    chk_eq("clr_sv_f_reset", f_reset, 1);
    model_clear();
    step();
    chk_eq("clr_sv_f_reset_drop", f_reset, 0);

    // Window fill
    for (int i = 0; i < 5; i++) begin
      send(t2_in[i], 1'b1);
      wait_out(k);
      chk_eq("t2_avg", m_data, t2_exp[i]);
      step();
    end

    // Warm-up suppression
    cfg_skip_warm = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) send(40, 1'b1);
    wait_out(k);
    chk_eq("t3_latency", k, 8);
    chk_eq("t3_m_data", m_data, 40);
    step();
    chk_eq("t3_out_count", out_count, out_exp);
    cfg_skip_warm = 1'b0;

    // Backpressure hold
    m_ready = 1'b0;
    send(int'($urandom_range(0, 1023)), 1'b1);
    wait_out(k);
    v = m_data;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_eq("t4_m_valid_hold", m_valid, 1);
      chk_eq("t4_m_data_hold", m_data, v);
      chk_eq("t4_s_ready_low", s_ready, 0);
      chk_eq("t4_no_strobe", f_strobe_in, 0);
    end
    m_ready = 1'b1;
    step();
    chk_eq("t4_out_count", out_count, out_exp);

    // Randomized samples, gaps and backpressure
    for (int i = 0; i < 12; i++) begin
      g = int'($urandom_range(0, 3));
      cfg_gap = GW'(g);
      m_ready = 1'b0;
      send(int'($urandom_range(0, 1023)), 1'b1);
      wait_out(k);
      chk_eq("rnd_latency", k, 8);
      repeat (int'($urandom_range(0, 3))) step();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      n = 0;
      while (!s_ready && n < 50) begin
        step();
        n++;
      end
      chk_eq("rnd_gap", n, g);
    end
    m_ready = 1'b1;
    chk_eq("rnd_out_count", out_count, out_exp);

    // clear during WAIT_F
    cfg_gap = '0;
    send(int'($urandom_range(1, 1023)), 1'b0);
    step();
    chk_eq("t6_busy", busy, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_eq("t6_idle", busy, 0);
    chk_eq("t6_s_ready", s_ready, 1);
    chk_eq("t6_f_reset", f_reset, 1);
    chk_eq("t6_m_valid", m_valid, 0);
    model_clear();
    step();
    chk_eq("t6_f_reset_drop", f_reset, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_eq("t6_no_m_valid", m_valid, 0);
    end

    // Watchdog abort
    filt_dead = 1'b1;
    cfg_gap = 8'd2;
    send(5, 1'b0);
    k = 0;
    while (!err_timeout && k < 200) begin
      step();
      k++;
    end
    chk_eq("t5_timeout_cycles", k, TO + 1);
    chk_eq("t5_no_m_valid", m_valid, 0);
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    chk_eq("t5_gap", n, 2);
    @(negedge clk);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    chk_eq("t5_err_sticky", err_timeout, 1);
    chk_eq("t5_count_kept", out_count, out_exp);
    filt_dead = 1'b0;
    cfg_gap = '0;

    // Recovery after clear
    send(16, 1'b1);
    wait_out(k);
    chk_eq("rec_m_data", m_data, 4);
    step();
    chk_eq("exp_q_drained", exp_q.size(), 0);

    // Reset mid-operation
    send(9, 1'b0);
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_eq("mr_busy", busy, 0);
    chk_eq("mr_out_count", out_count, 0);
    chk_eq("mr_err", err_timeout, 0);
    chk_eq("mr_m_valid", m_valid, 0);
    chk_eq("mr_s_ready", s_ready, 1);
    chk_eq("mr_f_reset", f_reset, 1);
    chk_eq("mr_f_data_in", f_data_in, 0);
    chk_eq("mr_m_data", m_data, 0);
    @(negedge clk);
    reset = 1'b0;
    out_exp = '0;
    model_clear();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
